// File: rtl/ysyx_22040386_mem_lsu.sv
// MEM-stage load/store unit: EX/MEM request -> valid/ready data bus -> aligned, extended load data.
// Store 3 cycles, load 4 cycles minimum; stalls the pipeline until the access completes.
module ysyx_22040386_mem_lsu #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                  i_MEM_LSU_clk,
   input  logic                  i_MEM_LSU_rst,
   input  logic                  i_MEM_LSU_MemRead,
   input  logic                  i_MEM_LSU_MemWrite,
   input  logic [2:0]            i_MEM_LSU_mem_mask,
   input  logic [ADDR_W-1:0]     i_MEM_LSU_addr,
   input  logic [DATA_W-1:0]     i_MEM_LSU_wr_data,
   output logic                  o_MEM_LSU_stall,
   output logic                  o_MEM_LSU_done,
   output logic [DATA_W-1:0]     o_MEM_LSU_rd_data,
   output logic                  o_MEM_LSU_addr_err,
   output logic                  o_MEM_LSU_req_valid,
   input  logic                  i_MEM_LSU_req_ready,
   output logic [ADDR_W-1:0]     o_MEM_LSU_req_addr,
   output logic                  o_MEM_LSU_req_wen,
   output logic [DATA_W-1:0]     o_MEM_LSU_req_wdata,
   output logic [DATA_W/8-1:0]   o_MEM_LSU_req_wstrb,
   input  logic                  i_MEM_LSU_rsp_valid,
   input  logic [DATA_W-1:0]     i_MEM_LSU_rsp_data
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     req_addr_q;
   logic                  req_wen_q;
   logic [DATA_W-1:0]     req_wdata_q;
   logic [DATA_W/8-1:0]   req_wstrb_q;
   logic [2:0]            off_q;
   logic [2:0]            mask_q;
   logic [DATA_W-1:0]     rd_data_q;

   logic                  access, illegal, misalign, load_en, capture;
   logic [2:0]            off;
   logic [7:0]            strb_base;
   logic [DATA_W-1:0]     wdata_sh, rsp_sh, rd_ext;

   assign access = i_MEM_LSU_MemRead | i_MEM_LSU_MemWrite;
   assign off    = i_MEM_LSU_addr[2:0];

   always_comb begin
      misalign  = 1'b0;
      strb_base = 8'h01;
      case (i_MEM_LSU_mem_mask[1:0])
         2'b00: begin misalign = 1'b0;            strb_base = 8'h01; end
         2'b01: begin misalign = off[0];          strb_base = 8'h03; end
         2'b10: begin misalign = (off[1:0] != 2'b00); strb_base = 8'h0F; end
         default: begin misalign = (off != 3'b000); strb_base = 8'hFF; end
      endcase
   end

   // Unsigned encodings have no meaning for stores, so they are rejected like mask=111.
   assign illegal = (i_MEM_LSU_MemRead & i_MEM_LSU_MemWrite)
                  | (i_MEM_LSU_mem_mask == 3'b111)
                  | (i_MEM_LSU_MemWrite & i_MEM_LSU_mem_mask[2])
                  | misalign;

   assign wdata_sh = i_MEM_LSU_wr_data << {off, 3'b000};
   assign rsp_sh   = i_MEM_LSU_rsp_data >> {off_q, 3'b000};

   always_comb begin
      rd_ext = rsp_sh;
      case (mask_q)
         3'b000:  rd_ext = {{56{rsp_sh[7]}},  rsp_sh[7:0]};
         3'b001:  rd_ext = {{48{rsp_sh[15]}}, rsp_sh[15:0]};
         3'b010:  rd_ext = {{32{rsp_sh[31]}}, rsp_sh[31:0]};
         3'b100:  rd_ext = {56'd0, rsp_sh[7:0]};
         3'b101:  rd_ext = {48'd0, rsp_sh[15:0]};
         3'b110:  rd_ext = {32'd0, rsp_sh[31:0]};
         default: rd_ext = rsp_sh;
      endcase
   end

   always_comb begin
      state_d            = state_q;
      o_MEM_LSU_stall    = 1'b0;
      o_MEM_LSU_done     = 1'b0;
      o_MEM_LSU_addr_err = 1'b0;
      load_en            = 1'b0;
      capture            = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               if (illegal) begin
                  o_MEM_LSU_addr_err = 1'b1;
               end else begin
                  o_MEM_LSU_stall = 1'b1;
                  load_en         = 1'b1;
                  state_d         = S_REQ;
               end
            end
         end
         S_REQ: begin
            o_MEM_LSU_stall = 1'b1;
            if (i_MEM_LSU_req_ready) state_d = req_wen_q ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            o_MEM_LSU_stall = 1'b1;
            if (i_MEM_LSU_rsp_valid) begin
               capture = 1'b1;
               state_d = S_DONE;
            end
         end
         default: begin
            o_MEM_LSU_done = 1'b1;
            state_d        = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_MEM_LSU_clk or posedge i_MEM_LSU_rst) begin
      if (i_MEM_LSU_rst) begin
         state_q     <= S_IDLE;
         req_addr_q  <= '0;
         req_wen_q   <= 1'b0;
         req_wdata_q <= '0;
         req_wstrb_q <= '0;
         off_q       <= 3'b000;
         mask_q      <= 3'b000;
         rd_data_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load_en) begin
            req_addr_q  <= {i_MEM_LSU_addr[ADDR_W-1:3], 3'b000};
            req_wen_q   <= i_MEM_LSU_MemWrite;
            req_wdata_q <= wdata_sh;
            req_wstrb_q <= strb_base << off;
            off_q       <= off;
            mask_q      <= i_MEM_LSU_mem_mask;
         end
         if (capture) rd_data_q <= rd_ext;
      end
   end

   assign o_MEM_LSU_req_valid = (state_q == S_REQ);
   assign o_MEM_LSU_req_addr  = req_addr_q;
   assign o_MEM_LSU_req_wen   = req_wen_q;
   assign o_MEM_LSU_req_wdata = req_wdata_q;
   assign o_MEM_LSU_req_wstrb = req_wstrb_q;
   assign o_MEM_LSU_rd_data   = rd_data_q;

endmodule

// File: tb/tb_ysyx_22040386_mem_lsu.sv
// Directed bench for the MEM-stage load/store unit.
module tb_ysyx_22040386_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  mask;
   logic [63:0] addr, wr_data;
   logic        stall, done, addr_err, req_valid, req_ready, req_wen, rsp_valid;
   logic [63:0] rd_data, req_addr, req_wdata, rsp_data;
   logic [7:0]  req_wstrb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ysyx_22040386_mem_lsu dut (
      .i_MEM_LSU_clk       (clk),
      .i_MEM_LSU_rst       (rst),
      .i_MEM_LSU_MemRead   (mem_read),
      .i_MEM_LSU_MemWrite  (mem_write),
      .i_MEM_LSU_mem_mask  (mask),
      .i_MEM_LSU_addr      (addr),
      .i_MEM_LSU_wr_data   (wr_data),
      .o_MEM_LSU_stall     (stall),
      .o_MEM_LSU_done      (done),
      .o_MEM_LSU_rd_data   (rd_data),
      .o_MEM_LSU_addr_err  (addr_err),
      .o_MEM_LSU_req_valid (req_valid),
      .i_MEM_LSU_req_ready (req_ready),
      .o_MEM_LSU_req_addr  (req_addr),
      .o_MEM_LSU_req_wen   (req_wen),
      .o_MEM_LSU_req_wdata (req_wdata),
      .o_MEM_LSU_req_wstrb (req_wstrb),
      .i_MEM_LSU_rsp_valid (rsp_valid),
      .i_MEM_LSU_rsp_data  (rsp_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_store(input string tag, input logic [2:0] m, input logic [63:0] a,
                           input logic [63:0] d, input int rdy_dly,
                           input logic [63:0] ea, input logic [63:0] ed, input logic [7:0] es);
      mem_write = 1'b1; mask = m; addr = a; wr_data = d; req_ready = 1'b0;
      #1;
      chk({tag, " idle stall"}, stall, 1);
      chk({tag, " idle valid"}, req_valid, 0);
      tick();
      for (int i = 0; i <= rdy_dly; i++) begin
         req_ready = (i == rdy_dly);
         #1;
         chk({tag, " req valid"}, req_valid, 1);
         chk({tag, " req addr"},  req_addr, ea);
         chk({tag, " req wdata"}, req_wdata, ed);
         chk({tag, " req wstrb"}, req_wstrb, es);
         chk({tag, " req wen"},   req_wen, 1);
         chk({tag, " req stall"}, stall, 1);
         tick();
      end
      req_ready = 1'b0;
      #1;
      chk({tag, " done"},       done, 1);
      chk({tag, " done stall"}, stall, 0);
      chk({tag, " done valid"}, req_valid, 0);
      mem_write = 1'b0;
      tick();
      #1;
      chk({tag, " done drop"}, done, 0);
   endtask

   task automatic do_load(input string tag, input logic [2:0] m, input logic [63:0] a,
                          input logic [63:0] rsp, input int wait_n, input logic [63:0] exp);
      mem_read = 1'b1; mask = m; addr = a; req_ready = 1'b1;
      #1;
      chk({tag, " idle stall"}, stall, 1);
      tick();
      #1;
      chk({tag, " req valid"}, req_valid, 1);
      chk({tag, " req wen"},   req_wen, 0);
      chk({tag, " req addr"},  req_addr, a & ~64'h7);
      tick();
      for (int i = 0; i <= wait_n; i++) begin
         rsp_valid = (i == wait_n);
         rsp_data  = (i == wait_n) ? rsp : 64'hDEAD_BEEF_CAFE_F00D;
         #1;
         chk({tag, " wait stall"}, stall, 1);
         chk({tag, " wait valid"}, req_valid, 0);
         tick();
      end
      rsp_valid = 1'b0;
      #1;
      chk({tag, " done"},       done, 1);
      chk({tag, " done stall"}, stall, 0);
      chk({tag, " rd_data"},    rd_data, exp);
      mem_read = 1'b0;
      tick();
      #1;
      chk({tag, " done drop"}, done, 0);
      chk({tag, " rd hold"},   rd_data, exp);
   endtask

   task automatic do_illegal(input string tag, input logic rd, input logic wr,
                             input logic [2:0] m, input logic [63:0] a);
      mem_read = rd; mem_write = wr; mask = m; addr = a; req_ready = 1'b1;
      #1;
      chk({tag, " err"},   addr_err, 1);
      chk({tag, " stall"}, stall, 0);
      chk({tag, " valid"}, req_valid, 0);
      tick();
      #1;
      chk({tag, " valid later"}, req_valid, 0);
      chk({tag, " done later"},  done, 0);
      chk({tag, " err held"},    addr_err, 1);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      chk({tag, " err clear"}, addr_err, 0);
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mask = 3'b000;
      addr = '0; wr_data = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      tick();
      tick();
      #1;
      chk("rst req_valid", req_valid, 0);
      chk("rst req_addr",  req_addr, 0);
      chk("rst req_wen",   req_wen, 0);
      chk("rst req_wdata", req_wdata, 0);
      chk("rst req_wstrb", req_wstrb, 0);
      chk("rst rd_data",   rd_data, 0);
      chk("rst done",      done, 0);
      chk("rst stall",     stall, 0);
      chk("rst addr_err",  addr_err, 0);
      tick();
      rst = 1'b0;
      tick();

      do_store("SW", 3'b010, 64'h8000_0004, 64'h1122_3344, 0,
               64'h8000_0000, 64'h1122_3344_0000_0000, 8'hF0);
      do_load("LB", 3'b000, 64'h8000_0003, 64'h0000_0000_8000_0000, 2,
              64'hFFFF_FFFF_FFFF_FF80);
      do_load("LHU", 3'b101, 64'h8000_0006, 64'hBEEF_0000_0000_0000, 0,
              64'h0000_0000_0000_BEEF);
      do_load("LW", 3'b010, 64'h8000_0004, 64'h8765_4321_0000_0000, 1,
              64'hFFFF_FFFF_8765_4321);
      do_load("LD", 3'b011, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 0,
              64'h0123_4567_89AB_CDEF);
      do_store("SH hold", 3'b001, 64'h8000_0012, 64'hABCD, 3,
               64'h8000_0010, 64'h0000_0000_ABCD_0000, 8'h0C);
      chk("rd after store", rd_data, 64'h0123_4567_89AB_CDEF);
      do_store("SB top", 3'b000, 64'h8000_0017, 64'h5A, 1,
               64'h8000_0010, 64'h5A00_0000_0000_0000, 8'h80);

      do_illegal("LW misalign", 1'b1, 1'b0, 3'b010, 64'h8000_0002);
      do_illegal("RD+WR",       1'b1, 1'b1, 3'b000, 64'h8000_0000);
      do_illegal("mask 111",    1'b1, 1'b0, 3'b111, 64'h8000_0000);
      do_illegal("SBU",         1'b0, 1'b1, 3'b100, 64'h8000_0000);
      do_illegal("SD misalign", 1'b0, 1'b1, 3'b011, 64'h8000_0004);

      // Reset arrives while a load waits for its response.
      mem_read = 1'b1; mask = 3'b010; addr = 64'h8000_0000; req_ready = 1'b1;
      tick();
      tick();
      #1;
      chk("mid wait stall", stall, 1);
      rst = 1'b1; mem_read = 1'b0;
      #1;
      chk("mid rst valid",   req_valid, 0);
      chk("mid rst stall",   stall, 0);
      chk("mid rst rd_data", rd_data, 0);
      chk("mid rst done",    done, 0);
      tick();
      rst = 1'b0;
      tick();
      rsp_valid = 1'b1; rsp_data = 64'h0000_0000_1234_5678;
      tick();
      rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("late rsp done",    done, 0);
         chk("late rsp rd_data", rd_data, 0);
         chk("late rsp stall",   stall, 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
